// File: rtl/gpio_debounce_multi.sv
// Multi-channel push-button debouncer.
// All channels share one sample-tick prescaler. Each channel has a two-flop
// synchroniser, polarity normalisation, a stable-sample counter that accepts
// a new level after STABLE_TICKS consecutive mismatching ticks, and a held
// counter that produces a single long-press strobe per press.
// Outputs: debounced level plus one-cycle rise/fall/long strobes, all registered.

module gpio_debounce_multi #(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 434,
   parameter int STABLE_TICKS = 4,
   parameter int LONG_TICKS   = 65535,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                src_clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CHANNELS-1:0] pb_in,
   output logic [CHANNELS-1:0] pb_level,
   output logic [CHANNELS-1:0] pb_rise,
   output logic [CHANNELS-1:0] pb_fall,
   output logic [CHANNELS-1:0] pb_long
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(STABLE_TICKS + 1);
   localparam int HW = $clog2(LONG_TICKS + 1);

   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HELD_LAST = HW'(LONG_TICKS - 1);
   localparam logic [HW-1:0] HELD_MAX  = HW'(LONG_TICKS);

   // Raw pin value that means "not pressed"; also the polarity flip mask.
   localparam logic [CHANNELS-1:0] INACTIVE = {CHANNELS{ACTIVE_LOW}};

   // ---------------------------------------------------------------------
   // Shared prescaler
   // ---------------------------------------------------------------------
   logic [PW-1:0] div_q;
   logic [PW-1:0] div_d;
   logic          tick;

   // Tick on the last count; disabling clears the count so the first tick
   // after re-enable is a full TICK_DIV period away.
   always_comb begin
      tick  = en && (div_q == TICK_LAST);
      div_d = div_q + PW'(1);
      if (!en || tick) begin
         div_d = '0;
      end
   end

   // Prescaler count register.
   always_ff @(posedge src_clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // ---------------------------------------------------------------------
   // Synchroniser and polarity normalisation
   // ---------------------------------------------------------------------
   logic [CHANNELS-1:0] sync1_q;
   logic [CHANNELS-1:0] sync2_q;
   logic [CHANNELS-1:0] norm;

   // Two-flop synchroniser; reset loads the idle pin level so that release
   // from reset never looks like a press edge. It keeps sampling while en=0
   // so a matching sample can still discard accumulated evidence.
   always_ff @(posedge src_clk or posedge rst) begin
      if (rst) begin
         sync1_q <= INACTIVE;
         sync2_q <= INACTIVE;
      end else begin
         sync1_q <= pb_in;
         sync2_q <= sync1_q;
      end
   end

   assign norm = sync2_q ^ INACTIVE;

   // ---------------------------------------------------------------------
   // Per-channel debounce and long-press logic
   // ---------------------------------------------------------------------
   logic [SW-1:0]       stab_q [CHANNELS];
   logic [SW-1:0]       stab_d [CHANNELS];
   logic [HW-1:0]       held_q [CHANNELS];
   logic [HW-1:0]       held_d [CHANNELS];
   logic [CHANNELS-1:0] level_q;
   logic [CHANNELS-1:0] level_d;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] fall_d;
   logic [CHANNELS-1:0] long_q;
   logic [CHANNELS-1:0] long_d;

   // Stable counter: any matching sample clears it; a mismatching tick
   // advances it, and the STABLE_TICKS-th one flips the level and strobes.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         stab_d[i]  = stab_q[i];
         level_d[i] = level_q[i];
         rise_d[i]  = 1'b0;
         fall_d[i]  = 1'b0;
         if (norm[i] == level_q[i]) begin
            stab_d[i] = '0;
         end else if (tick) begin
            if (stab_q[i] >= STAB_LAST) begin
               stab_d[i]  = '0;
               level_d[i] = ~level_q[i];
               rise_d[i]  = ~level_q[i];
               fall_d[i]  = level_q[i];
            end else begin
               stab_d[i] = stab_q[i] + SW'(1);
            end
         end
      end
   end

   // Held counter: counts ticks only while the registered level is high, so
   // the tick that sets the level is not counted. Saturation at LONG_TICKS
   // limits the long strobe to one per press; a release clears and re-arms.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         held_d[i] = held_q[i];
         long_d[i] = 1'b0;
         if (!level_q[i]) begin
            held_d[i] = '0;
         end else if (tick && (held_q[i] != HELD_MAX)) begin
            held_d[i] = held_q[i] + HW'(1);
            long_d[i] = (held_q[i] == HELD_LAST);
         end
      end
   end

   // Per-channel state and registered strobes; reset drops the level with
   // no fall strobe.
   always_ff @(posedge src_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            stab_q[i] <= '0;
            held_q[i] <= '0;
         end
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         long_q  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            stab_q[i] <= stab_d[i];
            held_q[i] <= held_d[i];
         end
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         long_q  <= long_d;
      end
   end

   assign pb_level = level_q;
   assign pb_rise  = rise_q;
   assign pb_fall  = fall_q;
   assign pb_long  = long_q;

endmodule

// File: tb/tb_gpio_debounce_multi.sv
// Bench for gpio_debounce_multi with CHANNELS=2, TICK_DIV=4, STABLE_TICKS=3,
// LONG_TICKS=5, ACTIVE_LOW=1. Expected strobe events (cycle, strobes, level)
// are queued by the stimulus; a negedge monitor pops one whenever any strobe
// is high. cyc counts rising edges since reset release.

module tb_gpio_debounce_multi;

   logic       src_clk = 1'b0;
   logic       rst     = 1'b1;
   logic       en      = 1'b1;
   logic [1:0] pb_in   = 2'b11;
   logic [1:0] pb_level;
   logic [1:0] pb_rise;
   logic [1:0] pb_fall;
   logic [1:0] pb_long;

   int cyc;
   int vectors = 0;
   int errors  = 0;

   typedef struct {
      int         cyc;
      logic [1:0] rise;
      logic [1:0] fall;
      logic [1:0] lng;
      logic [1:0] level;
   } ev_t;

   ev_t exp_q[$];

   gpio_debounce_multi #(
      .CHANNELS    (2),
      .TICK_DIV    (4),
      .STABLE_TICKS(3),
      .LONG_TICKS  (5),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .src_clk (src_clk),
      .rst     (rst),
      .en      (en),
      .pb_in   (pb_in),
      .pb_level(pb_level),
      .pb_rise (pb_rise),
      .pb_fall (pb_fall),
      .pb_long (pb_long)
   );

   always #5 src_clk = ~src_clk;

   always @(posedge src_clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Monitor: every strobe cycle must match the head of the expectation queue.
   always @(negedge src_clk) begin : monitor
      ev_t e;
      if (!rst && ((pb_rise | pb_fall | pb_long) != 2'b00)) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d got rise=%b fall=%b long=%b level=%b",
                     cyc, pb_rise, pb_fall, pb_long, pb_level);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.rise !== pb_rise || e.fall !== pb_fall ||
                e.lng !== pb_long || e.level !== pb_level) begin
               errors++;
               $display("FAIL strobe_event got cyc=%0d rise=%b fall=%b long=%b level=%b, want cyc=%0d rise=%b fall=%b long=%b level=%b",
                        cyc, pb_rise, pb_fall, pb_long, pb_level,
                        e.cyc, e.rise, e.fall, e.lng, e.level);
            end
         end
      end
   end

   task automatic expect_ev(input int c, input logic [1:0] r, input logic [1:0] f,
                            input logic [1:0] l, input logic [1:0] lv);
      ev_t e;
      e.cyc = c; e.rise = r; e.fall = f; e.lng = l; e.level = lv;
      exp_q.push_back(e);
   endtask

   // Advance to the negedge where cyc==n, then 1 time unit past it.
   task automatic at_cyc(input int n);
      int guard = 0;
      @(negedge src_clk);
      while (cyc != n && guard < 1000) begin
         @(negedge src_clk);
         guard++;
      end
      if (cyc != n) begin
         vectors++;
         errors++;
         $display("FAIL at_cyc_timeout got cyc=%0d want %0d", cyc, n);
      end
      #1;
   endtask

   task automatic chk_level(input string name, input logic [1:0] exp);
      vectors++;
      if (pb_level !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got level=%b want %b", name, cyc, pb_level, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      vectors++;
      if ({pb_level, pb_rise, pb_fall, pb_long} !== 8'h00) begin
         errors++;
         $display("FAIL %s cyc=%0d got level=%b rise=%b fall=%b long=%b want all 0",
                  name, cyc, pb_level, pb_rise, pb_fall, pb_long);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      ev_t e;
      // Reset with pins idle, then release between edges.
      repeat (3) @(negedge src_clk);
      chk_zero("reset_state");
      #1 rst = 1'b0;

      // Test 1: quiet for 40 cycles, then press channel 0.
      for (int c = 1; c <= 40; c++) begin
         at_cyc(c);
         chk_zero("idle_after_reset");
      end
      pb_in[0] = 1'b0;
      expect_ev(52, 2'b01, 2'b00, 2'b00, 2'b01);
      at_cyc(51); chk_level("press0_before_accept", 2'b00);
      at_cyc(52); chk_level("press0_accept", 2'b01);

      // Test 3: keep holding -> single long strobe, then release.
      expect_ev(72, 2'b00, 2'b00, 2'b01, 2'b01);
      at_cyc(171); chk_level("long_hold", 2'b01);
      at_cyc(172);
      pb_in[0] = 1'b1;
      expect_ev(184, 2'b00, 2'b01, 2'b00, 2'b00);
      at_cyc(183); chk_level("release0_before_accept", 2'b01);
      at_cyc(190); chk_level("release0_done", 2'b00);

      // Test 2: bounce every 3 cycles; never enough consecutive ticks.
      for (int i = 0; i < 20; i++) begin
         at_cyc(200 + 3 * i);
         pb_in[0] = (i % 2 == 1) ? 1'b1 : 1'b0;
      end
      at_cyc(260);
      pb_in[0] = 1'b1;
      at_cyc(270); chk_level("bounce_ignored", 2'b00);

      // Test 4: short press on channel 1, held counter peaks at LONG_TICKS-1.
      at_cyc(280);
      pb_in[1] = 1'b0;
      expect_ev(292, 2'b10, 2'b00, 2'b00, 2'b10);
      at_cyc(291); chk_level("press1_before_accept", 2'b00);
      at_cyc(292); chk_level("press1_accept", 2'b10);
      at_cyc(296);
      pb_in[1] = 1'b1;
      expect_ev(308, 2'b00, 2'b10, 2'b00, 2'b00);
      at_cyc(307); chk_level("short_press_held", 2'b10);
      at_cyc(308); chk_level("short_press_released", 2'b00);

      // Test 5: disable after two mismatching ticks; resume finishes on first tick.
      at_cyc(320);
      pb_in[0] = 1'b0;
      at_cyc(328);
      en = 1'b0;
      at_cyc(377); chk_level("en_low_frozen", 2'b00);
      at_cyc(378);
      en = 1'b1;
      expect_ev(382, 2'b01, 2'b00, 2'b00, 2'b01);
      at_cyc(381); chk_level("en_resume_before_tick", 2'b00);
      at_cyc(382); chk_level("en_resume_accept", 2'b01);

      // Test 6: press channel 1 (coincides with channel 0 long), then reset.
      at_cyc(390);
      pb_in[1] = 1'b0;
      expect_ev(402, 2'b10, 2'b00, 2'b01, 2'b11);
      at_cyc(405); chk_level("both_pressed", 2'b11);
      rst = 1'b1;
      #1 chk_zero("async_reset_clear");
      repeat (3) @(negedge src_clk);
      chk_zero("reset_held");
      #1 rst = 1'b0;
      // Pins still low: both channels re-detect together.
      expect_ev(12, 2'b11, 2'b00, 2'b00, 2'b11);
      expect_ev(32, 2'b00, 2'b00, 2'b11, 2'b11);
      at_cyc(11); chk_level("redetect_before_accept", 2'b00);
      at_cyc(12); chk_level("redetect_accept", 2'b11);
      at_cyc(40);
      pb_in = 2'b11;
      expect_ev(52, 2'b00, 2'b11, 2'b00, 2'b00);
      at_cyc(51); chk_level("release_both_before", 2'b11);
      at_cyc(60); chk_level("release_both_done", 2'b00);

      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         errors++;
         $display("FAIL missing_event want cyc=%0d rise=%b fall=%b long=%b level=%b got none",
                  e.cyc, e.rise, e.fall, e.lng, e.level);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/gpio_debounce_multi.md
Name: gpio_debounce_multi

Overview:
Parametrised multi-channel push-button debouncer for the GPIO connect layer. It replaces the single-channel debouncer. It adds:
- N channels
- selectable input polarity
- input synchronisers
- an asynchronous reset
- one-cycle press/release event strobes
- a long-press event

All channels share one internal sample-tick prescaler running in the src_clk domain. Outputs feed UART command logic and the LED/GPIO register map.

Parameters:
CHANNELS, 4, number of independent button inputs (1..32)
TICK_DIV, 434, src_clk cycles per sample tick (>=2); 434 gives about 115.2 kHz from 50 MHz
STABLE_TICKS, 4, consecutive mismatching ticks required to accept a new level (>=1)
LONG_TICKS, 65535, ticks a press must be held before pb_long fires (>=1)
ACTIVE_LOW, 1, 1 means a raw 0 on pb_in is "pressed"; 0 means a raw 1 is "pressed"

Ports:
src_clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset; clears all state immediately
en  input  1  1 = prescaler runs; 0 = prescaler cleared, no ticks, all channel state frozen
pb_in  input  CHANNELS  raw asynchronous button pins
pb_level  output  CHANNELS  debounced level, 1 = pressed (after polarity normalisation)
pb_rise  output  CHANNELS  one-cycle strobe when pb_level goes 0->1
pb_fall  output  CHANNELS  one-cycle strobe when pb_level goes 1->0
pb_long  output  CHANNELS  one-cycle strobe when a press has been held LONG_TICKS ticks

Behaviour:
- Reset (async assert, sync release):
  - pb_level, pb_rise, pb_fall, pb_long = 0.
  - Prescaler count = 0.
  - Per-channel stable/held counters = 0.
  - Synchroniser flops are loaded with the inactive level (ACTIVE_LOW ? 1 : 0), so no spurious press at release.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1; count wraps to 0 the same cycle.
  - en=0 clears count to 0 and forces tick=0.
  - First tick after en rises: TICK_DIV cycles later.
- Synchroniser: 2 flops per channel.
  - norm[i] = sync2[i] XOR ACTIVE_LOW.
  - Input-to-norm latency is 2 cycles.
- Per-channel stable counter, width clog2(STABLE_TICKS+1):
  - In any cycle where norm == pb_level, the counter clears to 0, whether or not tick is high. A single matching sample discards accumulated evidence.
  - On tick with norm != pb_level:
    - counter < STABLE_TICKS-1: counter increments.
    - counter == STABLE_TICKS-1: pb_level toggles in the next cycle, counter clears, and the matching strobe (rise or fall) is 1 for that single cycle.
  - Between ticks with mismatch: counter holds.
- Held counter (long press), width clog2(LONG_TICKS+1):
  - Clears while pb_level = 0.
  - On each tick while pb_level = 1 it increments, saturating at LONG_TICKS.
  - The tick that moves it from LONG_TICKS-1 to LONG_TICKS produces pb_long = 1 for one cycle (the cycle after the tick).
  - pb_long fires at most once per press; a new press re-arms it.
  - The tick that sets pb_level is not counted; counting starts on the following tick.
- Simultaneous-event rules:
  - pb_rise and pb_fall are never 1 together on a channel.
  - pb_long and pb_fall are never 1 together, because pb_level=1 is required for the held increment.
- Mid-operation rules:
  - en=0 mid-debounce: counters hold; the mismatch clear still applies on a matching sample.
  - rst mid-press: pb_level drops to 0 immediately and no pb_fall is generated.
- Channel independence: channels are fully independent; identical stimulus on all channels produces identical, same-cycle outputs.
- Latency: first pb_level change occurs on the STABLE_TICKS-th tick after the first mismatching sampled tick, plus 1 cycle; the worst case is 2 + STABLE_TICKS*TICK_DIV + 1 cycles from the pin edge.

Test Plan:
- All tests use CHANNELS=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, ACTIVE_LOW=1, en=1.
1. Reset with pb_in=2'b11, release -> all outputs 0 for 40 cycles; pb_in[0]=0 held -> pb_rise[0] one cycle and pb_level[0]=1 exactly 1 cycle after the 3rd tick seeing norm=1; channel 1 stays 0.
2. Bounce: pb_in[0] toggles 0/1 every 3 cycles for 60 cycles, then returns to 1 -> pb_level[0] never changes, no strobes.
3. Long press: hold pb_in[0]=0 -> pb_rise[0], then pb_long[0] one cycle 5 ticks (20 cycles) after pb_level set; holding 100 more cycles gives no second pb_long; release -> pb_fall[0] after 3 ticks, pb_long not repeated.
4. Short press: hold pb_in[1]=0 for 3 ticks after level set, then release -> pb_rise[1] and pb_fall[1] each once, pb_long[1] never.
5. en=0 for 50 cycles while pb_in[0]=0 (mid-count after 2 ticks) -> no change; en=1 -> pb_level[0] sets on the 1st tick after resume (TICK_DIV+1 cycles).
6. Assert rst while pb_level=2'b11 -> outputs 0 within the same cycle (async); no pb_fall; after release with pins still 0, presses re-detect after 3 ticks.
